// File: rtl/risac_mem_if.sv
// risac_mem_if: instruction and data bus between the risac core and its local memory.
interface risac_mem_if;
  logic [31:0] iIbusAddr;
  logic [31:0] oIbusData;
  logic [31:0] oIbusIAddr;
  logic        oIbusWait;
  logic [31:0] iDbusAddr;
  logic        iDbusWe;
  logic [31:0] iDbusData;
  logic        iDbusRead;
  logic [3:0]  iDbusByteEn;
  logic [31:0] oDbusData;
  logic        oDbusWait;

  // Core side: issues fetches, loads and stores.
  modport master (
    output iIbusAddr, iDbusAddr, iDbusWe, iDbusData, iDbusRead, iDbusByteEn,
    input  oIbusData, oIbusIAddr, oIbusWait, oDbusData, oDbusWait
  );

  // Memory side: responds on both buses.
  modport slave (
    input  iIbusAddr, iDbusAddr, iDbusWe, iDbusData, iDbusRead, iDbusByteEn,
    output oIbusData, oIbusIAddr, oIbusWait, oDbusData, oDbusWait
  );
endinterface

// File: rtl/risac_mem.sv
// risac_mem: dual-port local program/data store for the risac core.
// Instruction port answers every cycle with latency 1; data reads are
// stretched by READ_WAIT cycles, writes complete without stalling.
module risac_mem #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned READ_WAIT = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  risac_mem_if.slave bus
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  // Counter preload for the WAIT state; unused when READ_WAIT is 1.
  localparam int unsigned WAIT_LOAD = (READ_WAIT > 1) ? READ_WAIT - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] iIdx;
  logic [ADDR_W-1:0] dIdx;
  logic [1:0]        dOff;
  logic [3:0]        wrMask;
  logic [31:0]       wrData;
  logic [31:0]       rdWord;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic              capture;
  logic              dWait;
  logic              ivalid;
  logic [31:0]       ibusData;
  logic [31:0]       ibusIAddr;
  logic [31:0]       dbusData;
  logic              unusedAddrBits_c;

  // Word indices alias modulo depth; byte offset steers lanes.
  assign iIdx   = bus.iIbusAddr[ADDR_W+1:2];
  assign dIdx   = bus.iDbusAddr[ADDR_W+1:2];
  assign dOff   = bus.iDbusAddr[1:0];
  assign wrMask = 4'(bus.iDbusByteEn << dOff);
  assign wrData = bus.iDbusData << {dOff, 3'b000};
  assign rdWord = mem[dIdx] >> {dOff, 3'b000};

  assign unusedAddrBits_c = ^bus.iDbusAddr[31:ADDR_W+2];

  // Byte-lane store; lanes shifted past lane 3 are simply dropped.
  always_ff @(posedge clk) begin
    if (bus.iDbusWe) begin
      for (int i = 0; i < 4; i++) begin
        if (wrMask[i]) mem[dIdx][8*i +: 8] <= wrData[8*i +: 8];
      end
    end
  end

  // Instruction fetch register; old word wins on a same-cycle store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibusData  <= '0;
      ibusIAddr <= '0;
      ivalid    <= 1'b0;
    end else begin
      ibusData  <= mem[iIdx];
      ibusIAddr <= bus.iIbusAddr;
      ivalid    <= 1'b1;
    end
  end

  // Data-read FSM state, wait counter and load-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dbusData <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (capture) dbusData <= rdWord;
    end
  end

  // Next-state, stall and capture decode for data reads.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    capture   = 1'b0;
    dWait     = 1'b0;
    unique case (state)
      IDLE: begin
        // A store alongside a read takes priority; the read is dropped.
        dWait = bus.iDbusRead & ~bus.iDbusWe;
        if (bus.iDbusRead && !bus.iDbusWe) begin
          if (READ_WAIT == 1) begin
            stateNext = RESP;
            capture   = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = 4'(WAIT_LOAD);
          end
        end
      end
      WAIT: begin
        dWait = 1'b1;
        if (!bus.iDbusRead) begin
          stateNext = IDLE;
        end else if (cnt == 4'd0) begin
          stateNext = RESP;
          capture   = 1'b1;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.oIbusData  = ibusData;
  assign bus.oIbusIAddr = ibusIAddr;
  assign bus.oIbusWait  = ~ivalid;
  assign bus.oDbusData  = dbusData;
  assign bus.oDbusWait  = dWait;

endmodule
